// File: rtl/writeback_queue.sv
// ---------------------------------------------------------------------------
// writeback_queue
//
// Small in-order buffer that sits between a result producer and the register
// file write port. Results {rd, data} are queued in a circular buffer and
// drained one per cycle into the register file, oldest first. While results
// wait in the queue, two read ports can look up the youngest pending value
// for a register so that readers never see stale register-file contents.
//
// Handshake (producer side): a result transfers on a rising edge when
// in_valid && in_ready. in_ready is simply "not full"; it never looks at
// in_valid or at a pop in the same cycle, so a full queue stays closed for
// one cycle even while it drains. An offer to register 0 completes the
// handshake but is dropped, since x0 is never written.
//
// Ports:
//   clock, reset        rising-edge clock; synchronous active-high reset
//   in_valid/in_ready   producer handshake
//   in_rd, in_data      destination register and value being offered
//   drain_hold          stalls the register-file write (and so the pop)
//   rf_regwrite         register-file write enable (head entry)
//   rf_wr, rf_wdata     head entry address/data, zero when empty
//   rr1_in, rr2_in      register numbers currently being read
//   hit1/fwd1,hit2/fwd2 pending-value lookup for each read port
//   count, empty, full  occupancy status
// ---------------------------------------------------------------------------
module writeback_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_rd,
  input  logic [W-1:0]             in_data,
  input  logic                     drain_hold,
  output logic                     rf_regwrite,
  output logic [4:0]               rf_wr,
  output logic [W-1:0]             rf_wdata,
  input  logic [4:0]               rr1_in,
  input  logic [4:0]               rr2_in,
  output logic                     hit1,
  output logic                     hit2,
  output logic [W-1:0]             fwd1,
  output logic [W-1:0]             fwd2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry storage. Contents are not reset: an entry is only ever observed
  // through the head/count bookkeeping, which is reset.
  logic [4:0]    r_rd   [DEPTH];
  logic [W-1:0]  r_data [DEPTH];

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  // Slot k is the k-th oldest pending entry; live when k < count.
  logic [AW-1:0] w_slot_idx  [DEPTH];
  logic          w_slot_live [DEPTH];

  logic          w_hit1;
  logic          w_hit2;
  logic [W-1:0]  w_fwd1;
  logic [W-1:0]  w_fwd2;

  // -------------------------------------------------------------------------
  // Status and handshake
  // -------------------------------------------------------------------------
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  assign in_ready = !w_full;
  assign count    = r_count;
  assign empty    = w_empty;
  assign full     = w_full;

  // x0 offers are accepted by the handshake but never stored.
  assign w_push = in_valid && !w_full && (in_rd != 5'd0);

  // -------------------------------------------------------------------------
  // Register-file write side: the head entry is presented straight from
  // storage, so a result can never reach rf_* in the cycle it is offered.
  // -------------------------------------------------------------------------
  assign rf_regwrite = !w_empty && !drain_hold;
  assign rf_wr       = w_empty ? 5'd0    : r_rd[r_head];
  assign rf_wdata    = w_empty ? '0      : r_data[r_head];
  assign w_pop       = rf_regwrite;

  // -------------------------------------------------------------------------
  // Forwarding lookup. Slots are walked oldest to youngest and each match
  // overrides the previous one, so the youngest matching entry wins. The
  // head is included even while it is being written this cycle.
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    assign w_slot_idx[g]  = r_head + AW'(g);
    assign w_slot_live[g] = (CW'(g) < r_count);
  end

  always_comb begin
    w_hit1 = 1'b0;
    w_fwd1 = '0;
    w_hit2 = 1'b0;
    w_fwd2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_slot_live[k] && (rr1_in != 5'd0) && (r_rd[w_slot_idx[k]] == rr1_in)) begin
        w_hit1 = 1'b1;
        w_fwd1 = r_data[w_slot_idx[k]];
      end
      if (w_slot_live[k] && (rr2_in != 5'd0) && (r_rd[w_slot_idx[k]] == rr2_in)) begin
        w_hit2 = 1'b1;
        w_fwd2 = r_data[w_slot_idx[k]];
      end
    end
  end

  assign hit1 = w_hit1;
  assign hit2 = w_hit2;
  assign fwd1 = w_fwd1;
  assign fwd2 = w_fwd2;

  // -------------------------------------------------------------------------
  // Pointer and occupancy state. Reset wins over any push/pop that cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + AW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry write port. Suppressed under reset so a discarded offer never
  // lands in storage.
  always_ff @(posedge clock) begin
    if (!reset && w_push) begin
      r_rd[r_tail]   <= in_rd;
      r_data[r_tail] <= in_data;
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
module tb_writeback_queue;

  localparam int W     = 32;
  localparam int DEPTH = 4;

  // -------------------------------------------------------------------------
  // Clock / reset block
  // -------------------------------------------------------------------------
  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_rd;
  logic [W-1:0]  in_data;
  logic          drain_hold;
  logic          rf_regwrite;
  logic [4:0]    rf_wr;
  logic [W-1:0]  rf_wdata;
  logic [4:0]    rr1_in;
  logic [4:0]    rr2_in;
  logic          hit1;
  logic          hit2;
  logic [W-1:0]  fwd1;
  logic [W-1:0]  fwd2;
  logic [2:0]    count;
  logic          empty;
  logic          full;

  always #5 clock = ~clock;

  writeback_queue #(.W(W), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rd       (in_rd),
    .in_data     (in_data),
    .drain_hold  (drain_hold),
    .rf_regwrite (rf_regwrite),
    .rf_wr       (rf_wr),
    .rf_wdata    (rf_wdata),
    .rr1_in      (rr1_in),
    .rr2_in      (rr2_in),
    .hit1        (hit1),
    .hit2        (hit2),
    .fwd1        (fwd1),
    .fwd2        (fwd2),
    .count       (count),
    .empty       (empty),
    .full        (full)
  );

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]   rd;
    logic [W-1:0] data;
  } ent_t;

  ent_t          mq[$];        // reference model: pending results, oldest first
  logic [W+4:0]  exp_q[$];     // expected register-file writes {rd,data}
  logic [W+4:0]  obs_q[$];     // writes seen on the DUT rf_* port

  task automatic chk(input string nm, input int tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d] actual=%0h required=%0h", nm, tag, act, exp);
    end
  endtask

  // Reference model outputs, from the queue contents alone.
  task automatic model_check();
    int           n;
    logic         h1, h2;
    logic [W-1:0] f1, f2;
    n  = mq.size();
    h1 = 1'b0; h2 = 1'b0; f1 = '0; f2 = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!h1 && rr1_in != 5'd0 && mq[i].rd == rr1_in) begin h1 = 1'b1; f1 = mq[i].data; end
      if (!h2 && rr2_in != 5'd0 && mq[i].rd == rr2_in) begin h2 = 1'b1; f2 = mq[i].data; end
    end
    chk("m_count",    n, 64'(count),       64'(n));
    chk("m_empty",    n, 64'(empty),       64'(n == 0));
    chk("m_full",     n, 64'(full),        64'(n == DEPTH));
    chk("m_in_ready", n, 64'(in_ready),    64'(n < DEPTH));
    chk("m_regwrite", n, 64'(rf_regwrite), 64'(n > 0 && !drain_hold));
    chk("m_rf_wr",    n, 64'(rf_wr),       64'((n > 0) ? mq[0].rd : 5'd0));
    chk("m_rf_wdata", n, 64'(rf_wdata),    64'((n > 0) ? mq[0].data : 32'd0));
    chk("m_hit1",     n, 64'(hit1),        64'(h1));
    chk("m_fwd1",     n, 64'(fwd1),        64'(f1));
    chk("m_hit2",     n, 64'(hit2),        64'(h2));
    chk("m_fwd2",     n, 64'(fwd2),        64'(f2));
  endtask

  task automatic model_update();
    int n;
    bit rw, acc;
    n   = mq.size();
    rw  = (n > 0) && !drain_hold;
    acc = in_valid && (n < DEPTH) && (in_rd != 5'd0);
    if (reset) begin
      mq.delete();
    end else begin
      if (rw)  mq.delete(0);
      if (acc) mq.push_back({in_rd, in_data});
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks: inputs change #1 after a rising edge; outputs are sampled
  // on the falling edge.
  // -------------------------------------------------------------------------
  task automatic drive(input logic rst, input logic vld, input logic [4:0] rd,
                       input logic [W-1:0] data, input logic hold,
                       input logic [4:0] r1, input logic [4:0] r2);
    reset = rst; in_valid = vld; in_rd = rd; in_data = data;
    drain_hold = hold; rr1_in = r1; rr2_in = r2;
  endtask

  task automatic sample();
    @(negedge clock);
    model_check();
    if (rf_regwrite === 1'b1) obs_q.push_back({rf_wr, rf_wdata});
  endtask

  task automatic advance();
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  // -------------------------------------------------------------------------
  // Directed vectors: inputs for one cycle and the outputs required during
  // that cycle (before the edge that consumes the inputs).
  // -------------------------------------------------------------------------
  typedef struct {
    logic         rst, vld;
    logic [4:0]   rd;
    logic [W-1:0] data;
    logic         hold;
    logic [4:0]   rr1, rr2;
    logic [2:0]   e_cnt;
    logic         e_rdy, e_rw;
    logic [4:0]   e_wr;
    logic [W-1:0] e_wd;
    logic         e_h1;
    logic [W-1:0] e_f1;
    logic         e_h2;
    logic [W-1:0] e_f2;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl[NV];

  function automatic vec_t mk(input int rst, input int vld, input int rd, input logic [31:0] data,
                              input int hold, input int rr1, input int rr2,
                              input int cnt, input int rdy, input int rw, input int wr,
                              input logic [31:0] wd, input int h1, input logic [31:0] f1,
                              input int h2, input logic [31:0] f2);
    vec_t v;
    v.rst = rst[0]; v.vld = vld[0]; v.rd = rd[4:0]; v.data = data; v.hold = hold[0];
    v.rr1 = rr1[4:0]; v.rr2 = rr2[4:0];
    v.e_cnt = cnt[2:0]; v.e_rdy = rdy[0]; v.e_rw = rw[0]; v.e_wr = wr[4:0]; v.e_wd = wd;
    v.e_h1 = h1[0]; v.e_f1 = f1; v.e_h2 = h2[0]; v.e_f2 = f2;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog [0] actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset for two edges; outputs are unknown before the first one.
    drive(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0);
    advance();
    advance();

    //           rst vld rd data          hold rr1 rr2 | cnt rdy rw wr wdata         h1 fwd1          h2 fwd2
    tbl[0]  = mk(0,  0,  0, 32'h0,        0,   3,  5,    0,  1,  0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
    // single write
    tbl[1]  = mk(0,  1,  5, 32'hDEADBEEF, 0,   5,  0,    0,  1,  0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
    tbl[2]  = mk(0,  0,  0, 32'h0,        0,   5,  0,    1,  1,  1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 32'h0);
    tbl[3]  = mk(0,  0,  0, 32'h0,        0,   5,  0,    0,  1,  0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
    // x0 discard
    tbl[4]  = mk(0,  1,  0, 32'hFFFFFFFF, 0,   0,  0,    0,  1,  0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
    tbl[5]  = mk(0,  0,  0, 32'h0,        0,   0,  0,    0,  1,  0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
    // forwarding priority, offer excluded from the search
    tbl[6]  = mk(0,  1,  7, 32'h11,       1,   7,  0,    0,  1,  0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
    tbl[7]  = mk(0,  1,  7, 32'h22,       1,   7,  0,    1,  1,  0, 7, 32'h11,       1, 32'h11,       0, 32'h0);
    tbl[8]  = mk(0,  0,  0, 32'h0,        1,   7,  0,    2,  1,  0, 7, 32'h11,       1, 32'h22,       0, 32'h0);
    tbl[9]  = mk(0,  0,  0, 32'h0,        0,   7,  0,    2,  1,  1, 7, 32'h11,       1, 32'h22,       0, 32'h0);
    tbl[10] = mk(0,  0,  0, 32'h0,        0,   7,  0,    1,  1,  1, 7, 32'h22,       1, 32'h22,       0, 32'h0);
    tbl[11] = mk(0,  0,  0, 32'h0,        0,   7,  0,    0,  1,  0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
    // reset mid-operation with an offer present
    tbl[12] = mk(0,  1,  9, 32'hA,        1,   0,  0,    0,  1,  0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
    tbl[13] = mk(0,  1, 10, 32'hB,        1,   0,  0,    1,  1,  0, 9, 32'hA,        0, 32'h0,        0, 32'h0);
    tbl[14] = mk(0,  1, 11, 32'hC,        1,   0,  0,    2,  1,  0, 9, 32'hA,        0, 32'h0,        0, 32'h0);
    tbl[15] = mk(1,  1, 12, 32'hD,        0,   9, 11,    3,  1,  1, 9, 32'hA,        1, 32'hA,        1, 32'hC);
    tbl[16] = mk(0,  0,  0, 32'h0,        0,   9, 12,    0,  1,  0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
    tbl[17] = mk(0,  0,  0, 32'h0,        0,  11, 10,    0,  1,  0, 0, 32'h0,        0, 32'h0,        0, 32'h0);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].rd, tbl[i].data, tbl[i].hold, tbl[i].rr1, tbl[i].rr2);
      sample();
      chk("t_count",    i, 64'(count),       64'(tbl[i].e_cnt));
      chk("t_in_ready", i, 64'(in_ready),    64'(tbl[i].e_rdy));
      chk("t_regwrite", i, 64'(rf_regwrite), 64'(tbl[i].e_rw));
      chk("t_rf_wr",    i, 64'(rf_wr),       64'(tbl[i].e_wr));
      chk("t_rf_wdata", i, 64'(rf_wdata),    64'(tbl[i].e_wd));
      chk("t_hit1",     i, 64'(hit1),        64'(tbl[i].e_h1));
      chk("t_fwd1",     i, 64'(fwd1),        64'(tbl[i].e_f1));
      chk("t_hit2",     i, 64'(hit2),        64'(tbl[i].e_h2));
      chk("t_fwd2",     i, 64'(fwd2),        64'(tbl[i].e_f2));
      advance();
    end

    // Fill and backpressure: four held pushes, a fifth offer refused.
    for (int r = 1; r <= 4; r++) begin
      drive(1'b0, 1'b1, 5'(r), 32'(r * 'h100), 1'b1, 5'd0, 5'd0);
      tick();
    end
    drive(1'b0, 1'b1, 5'd5, 32'h500, 1'b1, 5'd0, 5'd0);
    sample();
    chk("bp_full",     0, 64'(full),        64'(1));
    chk("bp_in_ready", 0, 64'(in_ready),    64'(0));
    chk("bp_count",    0, 64'(count),       64'(4));
    chk("bp_regwrite", 0, 64'(rf_regwrite), 64'(0));
    advance();
    drive(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0);
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("bp_drain_we", k, 64'(rf_regwrite), 64'(1));
      chk("bp_drain_wr", k, 64'(rf_wr),       64'(k + 1));
      chk("bp_drain_wd", k, 64'(rf_wdata),    64'((k + 1) * 'h100));
      advance();
    end
    sample();
    chk("bp_empty", 0, 64'(empty), 64'(1));
    advance();

    // Streaming push with concurrent pop; pointers wrap several times.
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] d;
      d = $urandom();
      drive(1'b0, 1'b1, 5'(i + 1), d, 1'b0, 5'd0, 5'd0);
      exp_q.push_back({5'(i + 1), d});
      sample();
      chk("st_count_le1", i, 64'(count <= 3'd1), 64'(1));
      advance();
    end
    drive(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("st_nwrites", 0, 64'(obs_q.size()), 64'(10));
    for (int i = 0; i < 10; i++) begin
      if (i < obs_q.size()) chk("st_order", i, 64'(obs_q[i]), 64'(exp_q[i]));
      else                  chk("st_missing", i, 64'(0), 64'(1));
    end

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      drive(1'($urandom_range(0, 49) == 0),
            1'($urandom_range(0, 9) < 6),
            5'($urandom_range(0, 7)),
            $urandom(),
            1'($urandom_range(0, 9) < 3),
            5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
